// File: rtl/pitch_pkg.sv
// Shared types and constants for the whistle tracker.
package pitch_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        ACTIVE    = 2'd2,
        RELEASE   = 2'd3
    } tracker_state_t;

endpackage

// File: rtl/pitch_whistle_tracker_frame_timeout.sv
// Frame watchdog: expire is high on the TIMEOUT_CYCLES-th consecutive cycle without reload.
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic reload,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt;

    assign expire = (cnt == LAST);

    // Restarts after every expiry so a long silence yields one miss per period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (reload || expire)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end

endmodule

// File: rtl/pitch_whistle_tracker.sv
// Tracks a steady in-band FFT peak and reports whistle start/end/bin.
// Optional WHISTLE_DURATION_EN adds the whistle_frames duration counter.
module pitch_whistle_tracker
    import pitch_pkg::*;
#(
    parameter int NSamples       = 256,
    parameter int BIN_LO         = 20,
    parameter int BIN_HI         = 100,
    parameter int CONFIRM_FRAMES = 4,
    parameter int RELEASE_FRAMES = 3,
    parameter int MAX_JITTER     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int KW            = $clog2(NSamples)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [KW-1:0] pitch_k,
    input  logic          pitch_valid,
    output logic          whistle_active,
    output logic          whistle_start,
    output logic          whistle_end,
    output logic [KW-1:0] whistle_bin
`ifdef WHISTLE_DURATION_EN
    ,
    output logic [15:0]   whistle_frames
`endif
);

    tracker_state_t   state;
    logic [KW-1:0]    ref_bin;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             expire;
    logic             frame;
    logic             in_band;
    logic             hit;
    logic             confirm;
    logic [KW:0]      diff;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .reload (pitch_valid),
        .expire (expire)
    );

    // One extra bit keeps the distance exact near bin 0 and NSamples-1.
    always_comb begin
        if ({1'b0, pitch_k} >= {1'b0, ref_bin})
            diff = {1'b0, pitch_k} - {1'b0, ref_bin};
        else
            diff = {1'b0, ref_bin} - {1'b0, pitch_k};
    end

    assign in_band = (pitch_k >= KW'(BIN_LO)) && (pitch_k <= KW'(BIN_HI));
    assign hit     = pitch_valid && in_band &&
                     ((state == IDLE) || (diff <= (KW+1)'(MAX_JITTER)));
    // A coincident pitch_valid wins over the timeout (hit needs pitch_valid).
    assign frame   = pitch_valid || expire;
    assign confirm = (state == CANDIDATE) && hit &&
                     (hit_cnt == CNT_W'(CONFIRM_FRAMES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ref_bin        <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            whistle_active <= 1'b0;
            whistle_start  <= 1'b0;
            whistle_end    <= 1'b0;
            whistle_bin    <= '0;
        end else begin
            whistle_start <= 1'b0;
            whistle_end   <= 1'b0;
            if (frame) begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            state   <= CANDIDATE;
                            ref_bin <= pitch_k;
                            hit_cnt <= CNT_W'(1);
                        end
                    end
                    CANDIDATE: begin
                        if (confirm) begin
                            state          <= ACTIVE;
                            ref_bin        <= pitch_k;
                            hit_cnt        <= '0;
                            whistle_active <= 1'b1;
                            whistle_start  <= 1'b1;
                            whistle_bin    <= pitch_k;
                        end else if (hit) begin
                            ref_bin <= pitch_k;
                            hit_cnt <= hit_cnt + CNT_W'(1);
                        end else begin
                            state   <= IDLE;
                            hit_cnt <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (hit) begin
                            ref_bin     <= pitch_k;
                            whistle_bin <= pitch_k;
                        end else if (RELEASE_FRAMES == 1) begin
                            state          <= IDLE;
                            whistle_active <= 1'b0;
                            whistle_end    <= 1'b1;
                        end else begin
                            state    <= RELEASE;
                            miss_cnt <= CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (hit) begin
                            state    <= ACTIVE;
                            miss_cnt <= '0;
                        end else if (miss_cnt == CNT_W'(RELEASE_FRAMES - 1)) begin
                            state          <= IDLE;
                            miss_cnt       <= '0;
                            whistle_active <= 1'b0;
                            whistle_end    <= 1'b1;
                        end else begin
                            miss_cnt <= miss_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef WHISTLE_DURATION_EN
    // Counts every frame seen while tracking, including the one that ends it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            whistle_frames <= '0;
        else if (frame) begin
            if (confirm)
                whistle_frames <= '0;
            else if (((state == ACTIVE) || (state == RELEASE)) && (whistle_frames != 16'hFFFF))
                whistle_frames <= whistle_frames + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pitch_whistle_tracker.sv
// Self-checking bench: directed table, timeout/reset sequences, random vs reference model.
module tb_pitch_whistle_tracker;

    localparam int KW   = 8;
    localparam int LO   = 20;
    localparam int HI   = 100;
    localparam int CONF = 4;
    localparam int REL  = 3;
    localparam int JIT  = 2;
    localparam int TMO  = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [KW-1:0] pitch_k;
    logic          pitch_valid;
    logic          whistle_active, whistle_start, whistle_end;
    logic [KW-1:0] whistle_bin;
`ifdef WHISTLE_DURATION_EN
    logic [15:0]   whistle_frames;
`endif

    pitch_whistle_tracker dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pitch_k       (pitch_k),
        .pitch_valid   (pitch_valid),
        .whistle_active(whistle_active),
        .whistle_start (whistle_start),
        .whistle_end   (whistle_end),
        .whistle_bin   (whistle_bin)
`ifdef WHISTLE_DURATION_EN
        ,
        .whistle_frames(whistle_frames)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whistle described as "on" plus run/fade counts.
    bit m_on;
    int m_run, m_fade, m_ref, m_idle;
    bit e_start, e_end;
    int e_bin, e_frames;

    function automatic void model_reset();
        m_on = 0; m_run = 0; m_fade = 0; m_ref = 0; m_idle = 0;
        e_start = 0; e_end = 0; e_bin = 0; e_frames = 0;
    endfunction

    function automatic void model_frame(input bit v, input int k);
        bit inband, near, h;
        int d;
        d      = (k > m_ref) ? k - m_ref : m_ref - k;
        inband = v && (k >= LO) && (k <= HI);
        near   = (d <= JIT);
        h      = inband && ((!m_on && m_run == 0) || near);
        if (m_on) begin
            if (e_frames < 65535) e_frames++;
            if (h && m_fade == 0) begin
                m_ref = k; e_bin = k;
            end else if (h) begin
                m_fade = 0;
            end else begin
                m_fade++;
                if (m_fade == REL) begin
                    m_on = 0; m_fade = 0; e_end = 1;
                end
            end
        end else if (h) begin
            m_run++; m_ref = k;
            if (m_run == CONF) begin
                m_on = 1; m_run = 0; e_start = 1; e_bin = k; e_frames = 0;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic void model_cycle(input bit v, input int k);
        e_start = 0; e_end = 0;
        if (v) begin
            m_idle = 0;
            model_frame(1, k);
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_idle = 0;
                model_frame(0, 0);
            end
        end
    endfunction

    task automatic tick(input bit v, input int k);
        pitch_valid = v;
        pitch_k     = KW'(k);
        model_cycle(v, k);
        @(negedge clk);
        pitch_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_active"}, whistle_active, m_on);
        chk({tag, "_start"},  whistle_start,  e_start);
        chk({tag, "_end"},    whistle_end,    e_end);
        chk({tag, "_bin"},    whistle_bin,    e_bin);
`ifdef WHISTLE_DURATION_EN
        chk({tag, "_frames"}, whistle_frames, e_frames);
`endif
    endtask

    // Idles until whistle_end, bounded; the cycle it shows up on is compared.
    task automatic wait_end(input string tag, input int exp_n);
        int seen;
        seen = -1;
        for (int n = 1; n <= exp_n + 200 && seen < 0; n++) begin
            tick(0, 0);
            check_model(tag);
            if (whistle_end === 1'b1) seen = n;
        end
        chk({tag, "_end_cycle"}, seen, exp_n);
        chk({tag, "_active_after"}, whistle_active, 1'b0);
    endtask

    typedef struct {
        bit v;
        int k;
        bit act;
        bit st;
        bit en;
        int bin;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit v, input int k, input bit a, input bit s,
                                input bit e, input int b);
        vec_t t;
        t.v = v; t.k = k; t.act = a; t.st = s; t.en = e; t.bin = b;
        tbl.push_back(t);
    endfunction

    initial begin
        int tone, k;

        // confirm at 46 after a slowly rising tone, then a 4-bin jump misses
        add(1, 40, 0, 0, 0, 0);
        add(1, 42, 0, 0, 0, 0);
        add(1, 44, 0, 0, 0, 0);
        add(1, 46, 1, 1, 0, 46);
        add(1, 48, 1, 0, 0, 48);
        add(1, 52, 1, 0, 0, 48);
        add(1, 48, 1, 0, 0, 48);
        // two misses (plus a non-frame cycle) then a hit keeps the whistle
        add(1, 10, 1, 0, 0, 48);
        add(0, 0,  1, 0, 0, 48);
        add(1, 10, 1, 0, 0, 48);
        add(1, 48, 1, 0, 0, 48);
        // three misses end it
        add(1, 10, 1, 0, 0, 48);
        add(1, 101, 1, 0, 0, 48);
        add(1, 19, 0, 0, 1, 48);
        // out-of-band bins never start anything
        add(1, 19, 0, 0, 0, 48);
        add(1, 19, 0, 0, 0, 48);
        add(1, 19, 0, 0, 0, 48);
        add(1, 101, 0, 0, 0, 48);
        add(1, 101, 0, 0, 0, 48);
        add(1, 101, 0, 0, 0, 48);
        // three hits broken by a miss, then a clean run of four
        add(1, 40, 0, 0, 0, 48);
        add(1, 40, 0, 0, 0, 48);
        add(1, 40, 0, 0, 0, 48);
        add(1, 10, 0, 0, 0, 48);
        add(1, 40, 0, 0, 0, 48);
        add(1, 40, 0, 0, 0, 48);
        add(1, 40, 0, 0, 0, 48);
        add(1, 40, 1, 1, 0, 40);

        reset_n = 1'b0; pitch_valid = 1'b0; pitch_k = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_active", whistle_active, 1'b0);
        chk("rst_start",  whistle_start,  1'b0);
        chk("rst_end",    whistle_end,    1'b0);
        chk("rst_bin",    whistle_bin,    0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            tick(tbl[i].v, tbl[i].k);
            chk($sformatf("tbl%0d_active", i), whistle_active, tbl[i].act);
            chk($sformatf("tbl%0d_start", i),  whistle_start,  tbl[i].st);
            chk($sformatf("tbl%0d_end", i),    whistle_end,    tbl[i].en);
            chk($sformatf("tbl%0d_bin", i),    whistle_bin,    tbl[i].bin);
        end

        // silence while active: three timeouts end the whistle
        wait_end("tmo", 3 * TMO);

        // pitch_valid landing on the expiry cycle is a frame, not a miss
        repeat (CONF) tick(1, 60);
        chk("coin_start", whistle_start, 1'b1);
        repeat (TMO - 1) tick(0, 0);
        tick(1, 60);
        check_model("coin_frame");
        chk("coin_active", whistle_active, 1'b1);
        wait_end("coin", 3 * TMO);

        // asynchronous reset in RELEASE clears at once, no end pulse
        repeat (CONF) tick(1, 50);
        tick(1, 10);
        chk("rel_active", whistle_active, 1'b1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_active", whistle_active, 1'b0);
        chk("arst_bin",    whistle_bin,    0);
        chk("arst_start",  whistle_start,  1'b0);
        chk("arst_end",    whistle_end,    1'b0);
        @(negedge clk);
        chk("arst_end_hold", whistle_end, 1'b0);
        reset_n = 1'b1;
        repeat (2) begin
            tick(0, 0);
            check_model("post_rst");
        end

`ifdef WHISTLE_DURATION_EN
        repeat (CONF) tick(1, 70);
        chk("dur_clear", whistle_frames, 0);
        repeat (10) tick(1, 70);
        repeat (REL) tick(1, 5);
        chk("dur_end", whistle_end, 1'b1);
        chk("dur_frames", whistle_frames, 13);
        repeat (5) tick(1, 5);
        chk("dur_frozen", whistle_frames, 13);
`endif

        // random frames around a wandering tone, with occasional long gaps
        tone = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) begin
                int gap;
                gap = $urandom_range(1000, 2200);
                for (int g = 0; g < gap; g++) begin
                    tick(0, $urandom % 256);
                    check_model("rnd_gap");
                end
            end
            if ($urandom % 12 == 0) tone = $urandom_range(15, 105);
            if ($urandom % 8 == 0) k = $urandom % 256;
            else k = tone + $urandom_range(0, 6) - 3;
            tick(($urandom % 3) != 0, k);
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pitch_whistle_tracker.md
PITCH_WHISTLE_TRACKER -- requirements
Module: pitch_whistle_tracker

Interface
REQ-001 SHALL have parameter NSamples, default 256: FFT length; bin index width KW = $clog2(NSamples).
REQ-002 SHALL have parameter BIN_LO, default 20: lowest in-band bin.
REQ-003 SHALL have parameter BIN_HI, default 100: highest in-band bin.
REQ-004 SHALL have parameter CONFIRM_FRAMES, default 4: consecutive hits to declare a whistle (legal range 2..15).
REQ-005 SHALL have parameter RELEASE_FRAMES, default 3: consecutive misses to end a whistle (legal range 1..15).
REQ-006 SHALL have parameter MAX_JITTER, default 2: maximum bin step between frames that still counts as the same tone.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 1024: clk cycles without pitch_valid that count as one miss frame.
REQ-008 SHALL have port clk, input, 1: FFT-domain clock; single clock.
REQ-009 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port pitch_k, input, KW: peak bin index from the peak finder.
REQ-011 SHALL have port pitch_valid, input, 1: one-cycle strobe per FFT frame.
REQ-012 SHALL have port whistle_active, output, 1: level, high while a whistle is tracked.
REQ-013 SHALL have port whistle_start, output, 1: one-cycle pulse on entry to ACTIVE.
REQ-014 SHALL have port whistle_end, output, 1: one-cycle pulse on return to IDLE from RELEASE.
REQ-015 SHALL have port whistle_bin, output, KW: last accepted bin of the current or most recent whistle.

Function
REQ-016 SHALL classify a frame as a hit when pitch_valid=1, BIN_LO<=pitch_k<=BIN_HI and, outside IDLE, |pitch_k-ref_bin|<=MAX_JITTER; every other frame is a miss.
REQ-017 SHALL treat TIMEOUT_CYCLES consecutive cycles without pitch_valid as one miss frame; the timer reloads on every pitch_valid and after every timeout.
REQ-018 SHALL implement FSM states IDLE, CANDIDATE, ACTIVE and RELEASE.
REQ-019 SHALL move from IDLE to CANDIDATE on a hit, setting ref_bin=pitch_k and hit_cnt=1; a miss in IDLE holds IDLE.
REQ-020 SHALL, in CANDIDATE, increment hit_cnt and update ref_bin on a hit, go to ACTIVE when hit_cnt reaches CONFIRM_FRAMES, and return to IDLE on a miss.
REQ-021 SHALL, in ACTIVE, update ref_bin on a hit, and on a miss go to RELEASE with miss_cnt=1.
REQ-022 SHALL, in RELEASE, return to ACTIVE with miss_cnt cleared on a hit, increment miss_cnt on a miss, and go to IDLE when miss_cnt reaches RELEASE_FRAMES.
REQ-023 SHALL register all outputs; each output change appears 1 clk after the frame (or timeout) that causes it.
REQ-024 SHALL drive whistle_active=1 in ACTIVE and RELEASE only.
REQ-025 SHALL update whistle_bin from ref_bin on every hit in ACTIVE, including the confirming hit, and hold it in all other states.
REQ-026 SHALL, when pitch_valid coincides with timeout expiry, process only the pitch_valid frame and reload the timer.
REQ-027 SHALL compute the jitter comparison as an unsigned absolute difference at KW+1 bits, with no wrap.

Reset
REQ-028 SHALL, while reset_n=0, force state=IDLE, all counters=0, ref_bin=0, whistle_active=0, whistle_start=0, whistle_end=0, whistle_bin=0 and reload the timer; this applies mid-whistle and produces no whistle_end pulse.

Configuration
REQ-029 SHALL, with WHISTLE_DURATION_EN defined, add output whistle_frames[15:0]: a count of frames spent in ACTIVE/RELEASE, saturating at 16'hFFFF, cleared on whistle_start and frozen at whistle_end; its reset value is 0.
REQ-030 SHALL, without WHISTLE_DURATION_EN, have neither the port nor the counter logic.

Structure
REQ-031 SHALL place the state enum type (tracker_state_t) and the counter width constant CNT_W=4 in shared package pitch_pkg.
REQ-032 SHALL implement the frame timeout as sub-module frame_timeout (reload input, expire output, parameter TIMEOUT_CYCLES).

Verification
REQ-033 SHALL verify: 4 frames at bin 40 -> whistle_start pulse 1 clk after the 4th frame; whistle_active=1; whistle_bin=40.
REQ-034 SHALL verify: frames 40,42,44,46,48 -> stays ACTIVE and whistle_bin=48; a following frame at 52 counts as a miss -> RELEASE.
REQ-035 SHALL verify: ACTIVE, then 2 misses and a hit at 48 -> remains active with no pulses; 3 consecutive misses -> whistle_end pulse and whistle_active=0.
REQ-036 SHALL verify: 3 hits at bin 19 or at bin 101 -> state stays IDLE; 3 hits at 40 followed by 1 frame at 10 -> IDLE with no whistle_start.
REQ-037 SHALL verify: in ACTIVE, pitch_valid stops -> whistle_end 3*1024 clk (+1) later; pitch_valid arriving at the timeout cycle is counted as a frame only.
REQ-038 SHALL verify: reset_n asserted in RELEASE -> all outputs 0 at once with no whistle_end; with WHISTLE_DURATION_EN defined, a 10-frame whistle with 3 release misses -> whistle_frames=13.
